mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 21 ++
 rtl/mem_responder_if.sv | 23 ++
 rtl/mem_tag_alloc.sv | 47 ++++
 rtl/mem_responder.sv | 81 ++++++++
 tb/tb_mem_responder.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared system definitions for the processor/memory bus: command encodings,
// the 4-bit memory tag type and the layout of one in-flight load return slot.
package mem_responder_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_command_e;

  typedef logic [3:0] mem_tag_t;

  typedef struct packed {
    logic        valid;
    mem_tag_t    tag;
    logic [63:0] data;
  } ret_slot_t;

endpackage

// File: rtl/mem_responder_if.sv
// Processor <-> memory bus bundle; the processor drives requests (master) and
// the responder returns acceptance tags and load data (slave).
interface mem_responder_if;
  import mem_responder_pkg::*;

  bus_command_e    proc2mem_command;
  logic [XLEN-1:0] proc2mem_addr;
  logic [63:0]     proc2mem_data;
  mem_tag_t        mem2proc_response;
  logic [63:0]     mem2proc_data;
  mem_tag_t        mem2proc_tag;

  modport master (
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    input  mem2proc_response, mem2proc_data, mem2proc_tag
  );

  modport slave (
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    output mem2proc_response, mem2proc_data, mem2proc_tag
  );

endinterface

// File: rtl/mem_tag_alloc.sv
// Tag allocator: busy bitmask over tags 1..NUM_TAGS, lowest-free priority pick,
// one allocate and one free per cycle, and a full flag.
module mem_tag_alloc
  import mem_responder_pkg::*;
#(
  parameter int NUM_TAGS = 15
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     alloc_i,
  input  logic     free_i,
  input  mem_tag_t free_tag_i,
  output mem_tag_t lowest_free_o,
  output logic     full_o
);

  logic [NUM_TAGS:1] busy_q;
  logic [NUM_TAGS:1] busy_d;

  // Scan downwards so the last hit is the lowest-numbered free tag; 0 when full.
  always_comb begin
    lowest_free_o = '0;
    for (int i = NUM_TAGS; i >= 1; i--) begin
      if (!busy_q[i]) lowest_free_o = mem_tag_t'(i);
    end
  end

  assign full_o = &busy_q;

  // A returning tag is still busy during its return cycle, so it can never be
  // the tag allocated in that same cycle.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i <= NUM_TAGS; i++) begin
      if (free_i && (free_tag_i == mem_tag_t'(i)))
        busy_d[i] = 1'b0;
      if (alloc_i && (lowest_free_o == mem_tag_t'(i)))
        busy_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_d;
  end

endmodule

// File: rtl/mem_responder.sv
// Tagged memory responder: accepts one load/store per cycle into a 64-bit
// backing store and returns load data a fixed MEM_LATENCY cycles later.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int MEM_LATENCY = 4,
  parameter int NUM_TAGS    = 15,
  parameter int MEM_DEPTH   = 256
) (
  input logic             clock,
  input logic             reset,
  mem_responder_if.slave  mem_bus
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  logic [IDX_W-1:0] word_idx;
  logic             is_req;
  logic             accept;
  logic             load_accept;
  logic             store_accept;
  logic             tags_full;
  mem_tag_t         free_tag;
  ret_slot_t        head_d;
  ret_slot_t        ret_slot;
  logic             unused_addr_bits;

  logic [63:0]      mem_q  [MEM_DEPTH];
  ret_slot_t        pipe_q [MEM_LATENCY];

  assign word_idx         = mem_bus.proc2mem_addr[3 +: IDX_W];
  assign unused_addr_bits = ^{mem_bus.proc2mem_addr[XLEN-1:3+IDX_W], mem_bus.proc2mem_addr[2:0]};

  assign is_req       = (mem_bus.proc2mem_command == BUS_LOAD) ||
                        (mem_bus.proc2mem_command == BUS_STORE);
  assign accept       = reset && is_req && !tags_full;
  assign load_accept  = accept && (mem_bus.proc2mem_command == BUS_LOAD);
  assign store_accept = accept && (mem_bus.proc2mem_command == BUS_STORE);

  assign mem_bus.mem2proc_response = accept ? free_tag : '0;

  mem_tag_alloc #(
    .NUM_TAGS (NUM_TAGS)
  ) u_tag_alloc (
    .clock         (clock),
    .reset         (reset),
    .alloc_i       (load_accept),
    .free_i        (ret_slot.valid),
    .free_tag_i    (ret_slot.tag),
    .lowest_free_o (free_tag),
    .full_o        (tags_full)
  );

  // Backing store is never reset; stores land at the acceptance edge.
  always_ff @(posedge clock) begin
    if (store_accept) mem_q[word_idx] <= mem_bus.proc2mem_data;
  end

  // Load data is captured into the head slot at acceptance, so a later store
  // to the same word cannot change what this load returns.
  always_comb begin
    head_d.valid = load_accept;
    head_d.tag   = load_accept ? free_tag : '0;
    head_d.data  = load_accept ? mem_q[word_idx] : '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MEM_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= head_d;
      for (int i = 1; i < MEM_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign ret_slot = pipe_q[MEM_LATENCY-1];

  assign mem_bus.mem2proc_tag  = ret_slot.valid ? ret_slot.tag  : '0;
  assign mem_bus.mem2proc_data = ret_slot.valid ? ret_slot.data : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a default instance and a 2-tag instance,
// with a scoreboard of expected load returns checked every cycle.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int LAT   = 4;
  localparam int IDX_W = 8;

  typedef struct {
    mem_tag_t    tag;
    logic [63:0] data;
    int          due;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  exp_t        sb [2][$];
  logic [63:0] model [2][256];

  mem_responder_if bbus ();
  mem_responder_if sbus ();

  mem_responder #(.MEM_LATENCY(4), .NUM_TAGS(15), .MEM_DEPTH(256)) u_big (
    .clock   (clock),
    .reset   (reset),
    .mem_bus (bbus)
  );

  mem_responder #(.MEM_LATENCY(4), .NUM_TAGS(2), .MEM_DEPTH(256)) u_small (
    .clock   (clock),
    .reset   (reset),
    .mem_bus (sbus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic present(input bit sel, input bus_command_e cmd,
                         input logic [XLEN-1:0] addr, input logic [63:0] data);
    bbus.proc2mem_command = BUS_NONE;
    bbus.proc2mem_addr    = '0;
    bbus.proc2mem_data    = '0;
    sbus.proc2mem_command = BUS_NONE;
    sbus.proc2mem_addr    = '0;
    sbus.proc2mem_data    = '0;
    if (sel) begin
      sbus.proc2mem_command = cmd;
      sbus.proc2mem_addr    = addr;
      sbus.proc2mem_data    = data;
    end else begin
      bbus.proc2mem_command = cmd;
      bbus.proc2mem_addr    = addr;
      bbus.proc2mem_data    = data;
    end
  endtask

  // Compare the combinational response, then update the model / scoreboard.
  task automatic check(input bit sel, input bus_command_e cmd,
                       input logic [XLEN-1:0] addr, input logic [63:0] data,
                       input mem_tag_t exp_resp, input string name);
    mem_tag_t got;
    int       idx;
    exp_t     e;
    got = sel ? sbus.mem2proc_response : bbus.mem2proc_response;
    idx = int'(addr[3 +: IDX_W]);
    n_assert++;
    assert (got === exp_resp)
    else begin
      n_fail++;
      $error("FAIL %s: response=%0d expected=%0d", name, got, exp_resp);
    end
    if (exp_resp != 0 && cmd == BUS_STORE) begin
      model[sel][idx] = data;
    end else if (exp_resp != 0 && cmd == BUS_LOAD) begin
      e.tag  = exp_resp;
      e.data = model[sel][idx];
      e.due  = cyc + LAT;
      sb[sel].push_back(e);
    end
    $display("txn %-16s dut%0d cmd=%0d addr=%h data=%h resp=%0d", name, sel, cmd, addr, data, got);
  endtask

  task automatic drive(input bit sel, input bus_command_e cmd,
                       input logic [XLEN-1:0] addr, input logic [63:0] data,
                       input mem_tag_t exp_resp, input string name);
    @(posedge clock);
    #1;
    present(sel, cmd, addr, data);
    @(negedge clock);
    check(sel, cmd, addr, data, exp_resp, name);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      present(1'b0, BUS_NONE, '0, '0);
      @(negedge clock);
    end
  endtask

  // Return monitor: every cycle each DUT must show exactly the due return or zeros.
  always @(negedge clock) begin
    mem_tag_t    got_tag;
    mem_tag_t    exp_tag;
    logic [63:0] got_data;
    logic [63:0] exp_data;
    for (int d = 0; d < 2; d++) begin
      got_tag  = (d == 0) ? bbus.mem2proc_tag  : sbus.mem2proc_tag;
      got_data = (d == 0) ? bbus.mem2proc_data : sbus.mem2proc_data;
      exp_tag  = '0;
      exp_data = '0;
      if (sb[d].size() > 0 && sb[d][0].due == cyc) begin
        exp_tag  = sb[d][0].tag;
        exp_data = sb[d][0].data;
        void'(sb[d].pop_front());
      end
      n_assert++;
      assert (got_tag === exp_tag)
      else begin
        n_fail++;
        $error("FAIL ret_tag dut%0d cyc%0d: tag=%0d expected=%0d", d, cyc, got_tag, exp_tag);
      end
      n_assert++;
      assert (got_data === exp_data)
      else begin
        n_fail++;
        $error("FAIL ret_data dut%0d cyc%0d: data=%h expected=%h", d, cyc, got_data, exp_data);
      end
      if (exp_tag != 0)
        $display("ret dut%0d cyc%0d tag=%0d data=%h", d, cyc, got_tag, got_data);
    end
  end

  initial begin
    present(1'b0, BUS_LOAD, 32'h1000, '0);
    repeat (3) @(negedge clock);
    check(1'b0, BUS_LOAD, 32'h1000, '0, 4'd0, "resp_in_reset");

    // Release reset and present a store in the very first cycle.
    @(posedge clock);
    #1;
    reset = 1'b1;
    present(1'b0, BUS_STORE, 32'h1000, 64'hDEADBEEF_01234567);
    @(negedge clock);
    check(1'b0, BUS_STORE, 32'h1000, 64'hDEADBEEF_01234567, 4'd1, "store_first");
    drive(1'b0, BUS_LOAD, 32'h1000, '0, 4'd1, "load_basic");
    idle(6);

    drive(1'b0, BUS_STORE, 32'h1008, 64'h1111_2222_3333_4444, 4'd1, "store_1008");
    drive(1'b0, BUS_STORE, 32'h1010, 64'h5555_6666_7777_8888, 4'd1, "store_1010");
    drive(1'b0, BUS_LOAD,  32'h1000, '0, 4'd1, "load_b2b_0");
    drive(1'b0, BUS_LOAD,  32'h1008, '0, 4'd2, "load_b2b_1");
    drive(1'b0, BUS_LOAD,  32'h1010, '0, 4'd3, "load_b2b_2");
    idle(6);

    drive(1'b0, BUS_STORE, 32'h1000, 64'hAAAA_0000_0000_0001, 4'd1, "store_lo");
    drive(1'b0, BUS_STORE, 32'h1800, 64'hBBBB_0000_0000_0002, 4'd1, "store_wrap");
    drive(1'b0, BUS_LOAD,  32'h1000, '0, 4'd1, "load_wrap");
    idle(6);

    drive(1'b0, BUS_NONE, 32'h1000, 64'hBAD0_BAD0_BAD0_BAD0, 4'd0, "none_cmd");
    drive(1'b0, BUS_LOAD, 32'h1000, '0, 4'd1, "load_after_none");
    idle(6);

    drive(1'b0, BUS_LOAD,  32'h1008, '0, 4'd1, "load_old");
    drive(1'b0, BUS_STORE, 32'h1008, 64'hCAFE_F00D_0000_0003, 4'd2, "store_over");
    drive(1'b0, BUS_LOAD,  32'h1008, '0, 4'd2, "load_new");
    idle(6);

    drive(1'b1, BUS_STORE, 32'h40, 64'h0123_4567_89AB_CDEF, 4'd1, "small_store");
    drive(1'b1, BUS_LOAD, 32'h40, '0, 4'd1, "small_ld0");
    drive(1'b1, BUS_LOAD, 32'h40, '0, 4'd2, "small_ld1");
    drive(1'b1, BUS_LOAD, 32'h40, '0, 4'd0, "small_full0");
    drive(1'b1, BUS_LOAD, 32'h40, '0, 4'd0, "small_full1");
    drive(1'b1, BUS_LOAD, 32'h40, '0, 4'd0, "small_ret_cyc");
    drive(1'b1, BUS_LOAD, 32'h40, '0, 4'd1, "small_reuse1");
    drive(1'b1, BUS_LOAD, 32'h40, '0, 4'd2, "small_reuse2");
    idle(8);

    // Reset two cycles after a load is accepted: that load must never return.
    drive(1'b0, BUS_LOAD, 32'h1000, '0, 4'd1, "load_pre_rst");
    idle(1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    sb[0].delete();
    sb[1].delete();
    present(1'b0, BUS_LOAD, 32'h1008, '0);
    @(negedge clock);
    check(1'b0, BUS_LOAD, 32'h1008, '0, 4'd0, "resp_mid_reset");
    @(posedge clock);
    #1;
    reset = 1'b1;
    present(1'b0, BUS_NONE, '0, '0);
    @(negedge clock);
    idle(6);
    drive(1'b0, BUS_LOAD, 32'h1000, '0, 4'd1, "load_post_rst");
    idle(8);

    n_assert++;
    assert (sb[0].size() == 0 && sb[1].size() == 0)
    else begin
      n_fail++;
      $error("FAIL sb_drain: pending=%0d/%0d expected=0/0", sb[0].size(), sb[1].size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
